// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - burst SRAM access controller with fixed wait states
// Serves 1-16 beat reads/writes, each SRAM access held WAIT_CYCLES+1 cycles.
module sram_controller #(
   parameter int ADDR_BITS   = 16,
   parameter int DATA_BITS   = 128,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 start_read,
   input  logic                 start_write,
   input  logic [ADDR_BITS-1:0] req_addr,
   input  logic [3:0]           burst_len,
   input  logic [DATA_BITS-1:0] wdata,
   input  logic                 wdata_valid,
   output logic                 wdata_ready,
   output logic [DATA_BITS-1:0] rdata,
   output logic                 rdata_valid,
   output logic                 busy,
   output logic                 done,
   output logic                 sram_read,
   output logic                 sram_write,
   output logic [ADDR_BITS-1:0] sram_addr,
   output logic [DATA_BITS-1:0] sram_wdata,
   input  logic [DATA_BITS-1:0] sram_rdata
);

   localparam int WW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYCLES);
   localparam logic [ADDR_BITS-1:0] BEAT_STRIDE = ADDR_BITS'(16);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WAIT_WDATA,
      WRITE,
      DONE
   } state_t;

   state_t state, state_nxt;

   logic [ADDR_BITS-1:0] addr_q;
   logic [DATA_BITS-1:0] wdata_q;
   logic [DATA_BITS-1:0] rdata_q;
   logic                 rvalid_q;
   logic [3:0]           beats_q;
   logic [WW-1:0]        wait_cnt;
   logic                 wait_last;
   logic                 more_beats;

   assign wait_last  = (wait_cnt == WAIT_LAST);
   assign more_beats = (beats_q != 4'd0);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      busy        = (state != IDLE);
      done        = (state == DONE);
      wdata_ready = (state == WAIT_WDATA);
      sram_read   = (state == READ);
      sram_write  = (state == WRITE);
      case (state)
         IDLE: begin
            if (start_read) begin
               state_nxt = READ;
            end else if (start_write) begin
               state_nxt = WAIT_WDATA;
            end
         end
         READ: begin
            if (wait_last) begin
               state_nxt = more_beats ? READ : DONE;
            end
         end
         WAIT_WDATA: begin
            if (wdata_valid) begin
               state_nxt = WRITE;
            end
         end
         WRITE: begin
            if (wait_last) begin
               state_nxt = more_beats ? WAIT_WDATA : DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath: address/beat bookkeeping advances on the final cycle of each access.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         beats_q  <= 4'd0;
         wait_cnt <= '0;
      end else begin
         rvalid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (start_read || start_write) begin
                  addr_q   <= req_addr;
                  beats_q  <= burst_len;
                  wait_cnt <= '0;
               end
            end
            READ: begin
               if (wait_last) begin
                  rdata_q  <= sram_rdata;
                  rvalid_q <= 1'b1;
                  wait_cnt <= '0;
                  if (more_beats) begin
                     beats_q <= beats_q - 4'd1;
                     addr_q  <= addr_q + BEAT_STRIDE;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            WAIT_WDATA: begin
               if (wdata_valid) begin
                  wdata_q  <= wdata;
                  wait_cnt <= '0;
               end
            end
            WRITE: begin
               if (wait_last) begin
                  wait_cnt <= '0;
                  if (more_beats) begin
                     beats_q <= beats_q - 4'd1;
                     addr_q  <= addr_q + BEAT_STRIDE;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: begin
               wait_cnt <= '0;
            end
         endcase
      end
   end

   assign sram_addr   = addr_q;
   assign sram_wdata  = wdata_q;
   assign rdata       = rdata_q;
   assign rdata_valid = rvalid_q;

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - scoreboard bench for sram_controller
module tb_sram_controller;

   localparam int AB = 16;
   localparam int DB = 128;
   localparam int WC = 1;

   logic          clk = 1'b0;
   logic          n_rst = 1'b0;
   logic          start_read = 1'b0;
   logic          start_write = 1'b0;
   logic [AB-1:0] req_addr = '0;
   logic [3:0]    burst_len = '0;
   logic [DB-1:0] wdata = '0;
   logic          wdata_valid = 1'b0;
   logic          wdata_ready;
   logic [DB-1:0] rdata;
   logic          rdata_valid;
   logic          busy;
   logic          done;
   logic          sram_read;
   logic          sram_write;
   logic [AB-1:0] sram_addr;
   logic [DB-1:0] sram_wdata;
   logic [DB-1:0] sram_rdata = '0;

   sram_controller #(.ADDR_BITS(AB), .DATA_BITS(DB), .WAIT_CYCLES(WC)) dut (
      .clk(clk), .n_rst(n_rst), .start_read(start_read), .start_write(start_write),
      .req_addr(req_addr), .burst_len(burst_len), .wdata(wdata), .wdata_valid(wdata_valid),
      .wdata_ready(wdata_ready), .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy),
      .done(done), .sram_read(sram_read), .sram_write(sram_write), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int done_seen = 0;
   int exp_done = 0;

   logic [DB-1:0]    exp_rd[$];
   logic [AB-1:0]    exp_ra[$];
   logic [AB+DB-1:0] exp_wr[$];
   logic [DB-1:0]    shadow[logic [AB-1:0]];

   task automatic check(input string tag, input logic [DB-1:0] got, input logic [DB-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [DB-1:0] pat(input logic [AB-1:0] a);
      return {8{a ^ 16'h3C5A}};
   endfunction

   // SRAM model: untouched locations return a pattern derived from the address
   logic [DB-1:0] mem [4096];
   bit            wv  [4096];
   always @(posedge clk) begin
      if (sram_write) begin
         mem[sram_addr[15:4]] <= sram_wdata;
         wv[sram_addr[15:4]]  <= 1'b1;
      end
   end
   always @(negedge clk) begin
      sram_rdata <= wv[sram_addr[15:4]] ? mem[sram_addr[15:4]] : pat(sram_addr);
   end

   int               rc = 0;
   int               wc = 0;
   logic [AB-1:0]    ra_h = '0;
   logic [AB+DB-1:0] wr_h = '0;
   logic [DB-1:0]    rd_h;

   always @(negedge clk) begin
      if (!n_rst) begin
         rc = 0;
         wc = 0;
      end else begin
         if (done) done_seen++;
         if (sram_read || sram_write) check("rd_wr_excl", sram_read & sram_write, 0);
         if (sram_read) begin
            if (rc == 0) begin
               if (exp_ra.size() == 0) check("unexp_read", 1, 0);
               else begin
                  ra_h = exp_ra.pop_front();
                  check("rd_addr", sram_addr, ra_h);
               end
            end else check("rd_addr_hold", sram_addr, ra_h);
            rc = (rc == WC) ? 0 : rc + 1;
         end
         if (sram_write) begin
            if (wc == 0) begin
               if (exp_wr.size() == 0) check("unexp_write", 1, 0);
               else begin
                  wr_h = exp_wr.pop_front();
                  check("wr_addr", sram_addr, wr_h[AB+DB-1:DB]);
                  check("wr_data", sram_wdata, wr_h[DB-1:0]);
               end
            end else begin
               check("wr_addr_hold", sram_addr, wr_h[AB+DB-1:DB]);
               check("wr_data_hold", sram_wdata, wr_h[DB-1:0]);
            end
            wc = (wc == WC) ? 0 : wc + 1;
         end
         if (rdata_valid) begin
            if (exp_rd.size() == 0) check("unexp_rvalid", 1, 0);
            else begin
               rd_h = exp_rd.pop_front();
               check("rdata", rdata, rd_h);
            end
         end
      end
   end

   task automatic idle_check();
      repeat (3) @(negedge clk);
      check("busy_idle", busy, 0);
      check("done_count", done_seen, exp_done);
      check("rd_q_empty", exp_rd.size(), 0);
      check("ra_q_empty", exp_ra.size(), 0);
      check("wr_q_empty", exp_wr.size(), 0);
   endtask

   task automatic do_read(input logic [AB-1:0] a, input logic [3:0] len, input bit both, input bit poke);
      logic [AB-1:0] t;
      int n;
      int first;
      for (int b = 0; b <= int'(len); b++) begin
         t = a + AB'(b * 16);
         exp_ra.push_back(t);
         exp_rd.push_back(shadow.exists(t) ? shadow[t] : pat(t));
      end
      @(negedge clk);
      req_addr = a; burst_len = len; start_read = 1'b1; start_write = both;
      @(negedge clk);
      start_read = 1'b0; start_write = 1'b0;
      n = 1;
      first = 0;
      while (1) begin
         if (rdata_valid && first == 0) first = n;
         if (poke && n == 2) begin
            start_read = 1'b1; start_write = 1'b1; req_addr = 16'h0700; burst_len = 4'd2;
         end
         if (poke && n == 3) begin
            start_read = 1'b0; start_write = 1'b0;
         end
         if (done || n >= 100) break;
         @(negedge clk);
         n++;
      end
      check("rd_first_valid", first, WC + 2);
      check("rd_done_cycle", n, (int'(len) + 1) * (WC + 1) + 1);
      check("done_with_valid", rdata_valid, 1);
      exp_done++;
      idle_check();
   endtask

   task automatic do_write(input logic [AB-1:0] a, input logic [3:0] len, input logic [DB-1:0] base, input int stall);
      logic [AB-1:0] t;
      logic [DB-1:0] d;
      int k;
      for (int b = 0; b <= int'(len); b++) begin
         t = a + AB'(b * 16);
         d = base ^ DB'(b);
         exp_wr.push_back({t, d});
         shadow[t] = d;
      end
      @(negedge clk);
      req_addr = a; burst_len = len; start_write = 1'b1;
      @(negedge clk);
      start_write = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         k = 0;
         while (!wdata_ready && k < 50) begin
            @(negedge clk);
            k++;
         end
         check("wr_ready_seen", wdata_ready, 1);
         if (b == 1) begin
            for (int s = 0; s < stall; s++) begin
               check("stall_ready", wdata_ready, 1);
               check("stall_no_write", sram_write, 0);
               @(negedge clk);
            end
         end
         wdata = base ^ DB'(b);
         wdata_valid = 1'b1;
         @(negedge clk);
         wdata_valid = 1'b0;
      end
      k = 0;
      while (!done && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("wr_done", done, 1);
      exp_done++;
      idle_check();
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_rvalid"}, rdata_valid, 0);
      check({tag, "_wready"}, wdata_ready, 0);
      check({tag, "_sread"}, sram_read, 0);
      check({tag, "_swrite"}, sram_write, 0);
      check({tag, "_saddr"}, sram_addr, 0);
      check({tag, "_swdata"}, sram_wdata, 0);
      check({tag, "_rdata"}, rdata, 0);
   endtask

   localparam logic [DB-1:0] DATA_A = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
   localparam logic [DB-1:0] DATA_B = 128'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0;

   initial begin
      #2;
      check_zero_outputs("reset");
      repeat (3) @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      check("post_reset_busy", busy, 0);

      do_write(16'h0040, 4'd0, DATA_A, 0);
      do_read(16'h0040, 4'd0, 1'b0, 1'b0);
      do_read(16'h0100, 4'd3, 1'b0, 1'b1);
      do_write(16'h0300, 4'd1, DATA_B, 5);
      do_read(16'h0300, 4'd1, 1'b0, 1'b0);
      do_read(16'hFFF0, 4'd1, 1'b0, 1'b0);
      do_read(16'h0200, 4'd0, 1'b1, 1'b0);

      // Abandon a burst write mid-access; only beat 0 ever reaches the SRAM
      exp_wr.push_back({16'h0800, DATA_B});
      @(negedge clk);
      req_addr = 16'h0800; burst_len = 4'd1; start_write = 1'b1;
      @(negedge clk);
      start_write = 1'b0;
      check("rst_wait_ready", wdata_ready, 1);
      wdata = DATA_B; wdata_valid = 1'b1;
      @(negedge clk);
      wdata_valid = 1'b0;
      check("pre_reset_write", sram_write, 1);
      #2 n_rst = 1'b0;
      #1 check_zero_outputs("async_rst");
      exp_wr.delete();
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      idle_check();
      do_read(16'h0040, 4'd0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
